// File: rtl/execute_muldiv_pkg.sv
// Shared types for the RV64 execute stage: pipeline payloads, ALU/muldiv op encodings,
// iterative unit state, and small op-classification helpers.
package execute_muldiv_pkg;

  typedef logic [63:0]  u64;
  typedef logic [127:0] u128;

  localparam int MUL_CYCLES = 64;
  localparam int DIV_CYCLES = 64;

  typedef enum logic [3:0] {
    MUL, MULH, MULHSU, MULHU, MULW,
    DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW
  } muldiv_op_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} muldiv_state_t;

  // Bit 4 set marks an RV64M op; the low nibble is then its muldiv_op_t code.
  typedef enum logic [4:0] {
    ALU_ADD = 5'h00, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW, ALU_PASSB,
    ALU_MUL = 5'h10, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_MULW,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU, ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW
  } alufunc_t;

  typedef struct packed {
    alufunc_t    alufunc;
    logic [1:0]  msize;
    logic        mem_rw;
    logic [1:0]  wb_sel;
  } ctl_t;

  typedef struct packed {
    u64   pc;
    logic valid;
    ctl_t ctl;
    u64   srca;
    u64   srcb;
    u64   rs2;
  } decode_data_t;

  typedef struct packed {
    u64   pc;
    logic valid;
    ctl_t ctl;
    u64   alu;
    u64   rs2;
  } execute_data_t;

  function automatic logic op_is_mul(input muldiv_op_t op);
    return op inside {MUL, MULH, MULHSU, MULHU, MULW};
  endfunction

  function automatic logic op_is_mulh(input muldiv_op_t op);
    return op inside {MULH, MULHSU, MULHU};
  endfunction

  function automatic logic op_is_rem(input muldiv_op_t op);
    return op inside {REM, REMU, REMW, REMUW};
  endfunction

  function automatic logic op_is_w(input muldiv_op_t op);
    return op inside {MULW, DIVW, DIVUW, REMW, REMUW};
  endfunction

  function automatic logic op_a_signed(input muldiv_op_t op);
    return op inside {MUL, MULH, MULHSU, MULW, DIV, REM, DIVW, REMW};
  endfunction

  function automatic logic op_b_signed(input muldiv_op_t op);
    return op inside {MUL, MULH, MULW, DIV, REM, DIVW, REMW};
  endfunction

  function automatic u64 sext32(input u64 v);
    return {{32{v[31]}}, v[31:0]};
  endfunction

  // W ops see only the low word, extended according to the operand's signedness.
  function automatic u64 prep_operand(input u64 v, input logic w, input logic sgn);
    if (w) return sgn ? sext32(v) : {32'd0, v[31:0]};
    return v;
  endfunction

endpackage

// File: rtl/execute_muldiv_unit.sv
// Iterative RV64M unit: 1-bit/cycle shift-add multiply and restoring divide on
// magnitudes with a final sign fix. Divide-by-zero and signed overflow finish in one cycle.
module execute_muldiv_unit
  import execute_muldiv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_in,
  input  muldiv_op_t op,
  input  u64         a,
  input  u64         b,
  input  logic       flush,
  input  logic       stall,
  output logic       busy,
  output logic       done,
  output u64         result
);

  muldiv_state_t state_reg;
  logic [6:0]    cnt_reg;
  u64            opnd_reg;
  u128           acc_reg;
  logic          neg_q_reg, neg_r_reg;
  muldiv_op_t    op_reg;
  u64            result_reg;

  logic w_op, sa, sb, div_zero, div_ovf;
  u64   ext_a, ext_b, mag_a, mag_b, early_res;

  always_comb begin
    w_op     = op_is_w(op);
    ext_a    = prep_operand(a, w_op, op_a_signed(op));
    ext_b    = prep_operand(b, w_op, op_b_signed(op));
    sa       = op_a_signed(op) & ext_a[63];
    sb       = op_b_signed(op) & ext_b[63];
    mag_a    = sa ? -ext_a : ext_a;
    mag_b    = sb ? -ext_b : ext_b;
    div_zero = ~op_is_mul(op) & (ext_b == 64'd0);
    // Most-negative / -1, checked at the operand width actually in use.
    div_ovf  = ~op_is_mul(op) & op_a_signed(op) & (ext_b == '1) &
               (ext_a == (w_op ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    if (op_is_rem(op)) early_res = div_zero ? ext_a : 64'd0;
    else               early_res = div_zero ? '1 : ext_a;
    if (w_op) early_res = sext32(early_res);
  end

  logic [64:0] add_sum;
  logic        sub_ok;
  u64          sub_diff;
  u128         acc_next, prod_fix;
  u64          q_fix, r_fix, final_res;
  logic [6:0]  cnt_last;

  always_comb begin
    add_sum  = {1'b0, acc_reg[127:64]} + (acc_reg[0] ? {1'b0, opnd_reg} : 65'd0);
    sub_ok   = acc_reg[127:63] >= {1'b0, opnd_reg};
    sub_diff = acc_reg[126:63] - opnd_reg;
    if (op_is_mul(op_reg))  acc_next = {add_sum, acc_reg[63:1]};
    else if (sub_ok)        acc_next = {sub_diff, acc_reg[62:0], 1'b1};
    else                    acc_next = {acc_reg[126:0], 1'b0};

    prod_fix = neg_q_reg ? -acc_next : acc_next;
    q_fix    = neg_q_reg ? -acc_next[63:0] : acc_next[63:0];
    r_fix    = neg_r_reg ? -acc_next[127:64] : acc_next[127:64];
    if (op_is_mulh(op_reg))      final_res = prod_fix[127:64];
    else if (op_is_mul(op_reg))  final_res = prod_fix[63:0];
    else if (op_is_rem(op_reg))  final_res = r_fix;
    else                         final_res = q_fix;
    if (op_is_w(op_reg)) final_res = sext32(final_res);

    cnt_last = op_is_mul(op_reg) ? 7'(MUL_CYCLES - 1) : 7'(DIV_CYCLES - 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= 7'd0;
      opnd_reg   <= 64'd0;
      acc_reg    <= 128'd0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      op_reg     <= MUL;
      result_reg <= 64'd0;
    end else if (flush) begin
      state_reg <= IDLE;
      cnt_reg   <= 7'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (valid_in) begin
            op_reg    <= op;
            neg_q_reg <= sa ^ sb;
            neg_r_reg <= sa;
            cnt_reg   <= 7'd0;
            // Multiply: multiplicand held, multiplier shifts out of acc low half.
            // Divide: divisor held, dividend shifts into the remainder half.
            opnd_reg  <= op_is_mul(op) ? mag_a : mag_b;
            acc_reg   <= {64'd0, op_is_mul(op) ? mag_b : mag_a};
            if (div_zero | div_ovf) begin
              result_reg <= early_res;
              state_reg  <= DONE;
            end else begin
              state_reg  <= BUSY;
            end
          end
        end
        BUSY: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + 7'd1;
          if (cnt_reg == cnt_last) begin
            result_reg <= final_res;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          if (!stall) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy   = (state_reg == BUSY);
  assign done   = (state_reg == DONE);
  assign result = result_reg;

endmodule

// File: rtl/execute_muldiv.sv
// RV64 execute stage: single-cycle ALU plus iterative RV64M unit that stalls via exe_wait.
// Optional MULDIV_FAST_MUL_EN: multiplies use a combinational 128-bit product instead.
module execute_muldiv
  import execute_muldiv_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  decode_data_t  dataD,
  input  logic          stall,
  input  logic          flush,
  output execute_data_t dataE_nxt,
  output logic          exe_wait
);

  alufunc_t   func;
  muldiv_op_t md_op;
  logic       is_muldiv, use_fast, start_iter;
  logic       md_busy, md_done;
  u64         alu_res, fast_res, md_result;

  assign func      = dataD.ctl.alufunc;
  assign is_muldiv = func[4];
  assign md_op     = muldiv_op_t'(func[3:0]);

`ifdef MULDIV_FAST_MUL_EN
  u64  fa64, fb64;
  u128 fprod;

  always_comb begin
    fa64  = prep_operand(dataD.srca, op_is_w(md_op), op_a_signed(md_op));
    fb64  = prep_operand(dataD.srcb, op_is_w(md_op), op_b_signed(md_op));
    // Low 128 bits of the sign-extended product are exact for every MUL* flavour.
    fprod = {{64{op_a_signed(md_op) & fa64[63]}}, fa64} *
            {{64{op_b_signed(md_op) & fb64[63]}}, fb64};
    fast_res = op_is_mulh(md_op) ? fprod[127:64] : fprod[63:0];
    if (op_is_w(md_op)) fast_res = sext32(fast_res);
  end

  assign use_fast = is_muldiv & op_is_mul(md_op);
`else
  assign fast_res = 64'd0;
  assign use_fast = 1'b0;
`endif

  assign start_iter = dataD.valid & is_muldiv & ~use_fast;

  execute_muldiv_unit u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .valid_in (start_iter),
    .op       (md_op),
    .a        (dataD.srca),
    .b        (dataD.srcb),
    .flush    (flush),
    .stall    (stall),
    .busy     (md_busy),
    .done     (md_done),
    .result   (md_result)
  );

  always_comb begin
    alu_res = 64'd0;
    case (func)
      ALU_ADD:   alu_res = dataD.srca + dataD.srcb;
      ALU_SUB:   alu_res = dataD.srca - dataD.srcb;
      ALU_AND:   alu_res = dataD.srca & dataD.srcb;
      ALU_OR:    alu_res = dataD.srca | dataD.srcb;
      ALU_XOR:   alu_res = dataD.srca ^ dataD.srcb;
      ALU_SLL:   alu_res = dataD.srca << dataD.srcb[5:0];
      ALU_SRL:   alu_res = dataD.srca >> dataD.srcb[5:0];
      ALU_SRA:   alu_res = $signed(dataD.srca) >>> dataD.srcb[5:0];
      ALU_SLT:   alu_res = {63'd0, $signed(dataD.srca) < $signed(dataD.srcb)};
      ALU_SLTU:  alu_res = {63'd0, dataD.srca < dataD.srcb};
      ALU_ADDW:  alu_res = sext32(dataD.srca + dataD.srcb);
      ALU_SUBW:  alu_res = sext32(dataD.srca - dataD.srcb);
      ALU_SLLW:  alu_res = sext32({32'd0, dataD.srca[31:0] << dataD.srcb[4:0]});
      ALU_SRLW:  alu_res = sext32({32'd0, dataD.srca[31:0] >> dataD.srcb[4:0]});
      ALU_SRAW:  alu_res = sext32({32'd0, $signed(dataD.srca[31:0]) >>> dataD.srcb[4:0]});
      ALU_PASSB: alu_res = dataD.srcb;
      default:   alu_res = 64'd0;
    endcase
  end

  assign exe_wait = start_iter & ~md_done;

  always_comb begin
    dataE_nxt.pc    = dataD.pc;
    dataE_nxt.ctl   = dataD.ctl;
    dataE_nxt.rs2   = dataD.rs2;
    dataE_nxt.alu   = is_muldiv ? (use_fast ? fast_res : md_result) : alu_res;
    // Never hand a half-finished or flushed instruction to the memory stage.
    dataE_nxt.valid = dataD.valid & ~flush & ~exe_wait & ~md_busy;
  end

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed-vector bench for execute_muldiv; adapts multiply latency to MULDIV_FAST_MUL_EN.
module tb_execute_muldiv;
  import execute_muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MW = 0;
`else
  localparam int MW = 65;
`endif
  localparam int DW = 65;

  logic          clk = 1'b0;
  logic          reset, stall, flush, exe_wait;
  decode_data_t  dataD;
  execute_data_t dataE_nxt;
  int            n_vec = 0;
  int            n_err = 0;
  int            waits;

  always #5 clk = ~clk;

  execute_muldiv dut (
    .clk       (clk),
    .reset     (reset),
    .dataD     (dataD),
    .stall     (stall),
    .flush     (flush),
    .dataE_nxt (dataE_nxt),
    .exe_wait  (exe_wait)
  );

  task automatic check_eq(input string tag, input u64 got, input u64 exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input alufunc_t f, input u64 a, input u64 b);
    dataD.valid       = 1'b1;
    dataD.ctl.alufunc = f;
    dataD.srca        = a;
    dataD.srcb        = b;
    dataD.rs2         = b;
    dataD.pc          = dataD.pc + 64'd4;
  endtask

  // Present one op, wait (bounded) for exe_wait to drop, then check result and latency.
  task automatic run_op(input string tag, input alufunc_t f, input u64 a, input u64 b,
                        input u64 exp, input int exp_waits);
    @(posedge clk); #1;
    flush = 1'b0;
    drive(f, a, b);
    waits = 0;
    @(negedge clk);
    while (exe_wait && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    $display("op %-10s a=%h b=%h alu=%h waits=%0d", tag, a, b, dataE_nxt.alu, waits);
    check_eq({tag, "_waits"}, 64'(waits), 64'(exp_waits));
    check_eq(tag, dataE_nxt.alu, exp);
    check_eq({tag, "_valid"}, 64'(dataE_nxt.valid), 64'd1);
    @(posedge clk); #1;
    dataD.valid = 1'b0;
  endtask

  initial begin
    dataD = '0;
    stall = 1'b0;
    flush = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_exe_wait", 64'(exe_wait), 64'd0);
    check_eq("rst_valid", 64'(dataE_nxt.valid), 64'd0);

    run_op("add",     ALU_ADD,   64'd5, 64'd7, 64'd12, 0);
    run_op("mul",     ALU_MUL,   64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, MW);
    run_op("div",     ALU_DIV,   -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, DW);
    run_op("rem",     ALU_REM,   -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, DW);
    run_op("divu_z",  ALU_DIVU,  64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("rem_ovf", ALU_REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    run_op("divw_ovf",ALU_DIVW,  64'h1_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    run_op("mulw",    ALU_MULW,  64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, MW);
    run_op("mulhu",   ALU_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, MW);
    run_op("mulhsu",  ALU_MULHSU,64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, MW);
    run_op("divu",    ALU_DIVU,  64'd100, 64'd7, 64'd14, DW);
    run_op("remu",    ALU_REMU,  64'd100, 64'd7, 64'd2, DW);
    run_op("remw_z",  ALU_REMW,  64'h1_8000_0005, 64'h1_0000_0000, 64'hFFFF_FFFF_8000_0005, 1);
    run_op("divuw",   ALU_DIVUW, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, DW);

    // Flush in the middle of a divide; the following multiply must start clean.
    @(posedge clk); #1;
    drive(ALU_DIV, 64'd100, 64'd3);
    repeat (20) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check_eq("flush_valid", 64'(dataE_nxt.valid), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    dataD.valid = 1'b0;
    run_op("mul_aft_fl", ALU_MUL, 64'd6, 64'd7, 64'd42, MW);

    // Flush together with a would-be accept: nothing may start.
    @(posedge clk); #1;
    drive(ALU_DIVU, 64'd100, 64'd0);
    flush = 1'b1;
    @(negedge clk);
    check_eq("flush_acc_valid", 64'(dataE_nxt.valid), 64'd0);
    run_op("divu_aft_fa", ALU_DIVU, 64'd100, 64'd7, 64'd14, DW);

    // Hold the result under downstream stall, then accept the next op right after retiring.
    @(posedge clk); #1;
    drive(ALU_MUL, 64'd6, 64'd7);
    stall = 1'b1;
    waits = 0;
    @(negedge clk);
    while (exe_wait && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    check_eq("stall_mul_waits", 64'(waits), 64'(MW));
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_alu", dataE_nxt.alu, 64'd42);
      check_eq("stall_exe_wait", 64'(exe_wait), 64'd0);
      if (i < 4) @(negedge clk);
    end
    $display("stall held alu=%h for 5 cycles", dataE_nxt.alu);
    @(posedge clk); #1 stall = 1'b0;
    @(negedge clk);
    check_eq("stall_rel_alu", dataE_nxt.alu, 64'd42);
    run_op("b2b_divu", ALU_DIVU, 64'd100, 64'd7, 64'd14, DW);

    // Reset while busy returns the unit to IDLE.
    @(posedge clk); #1;
    drive(ALU_DIV, 64'd100, 64'd3);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    dataD.valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_busy_exe_wait", 64'(exe_wait), 64'd0);
    run_op("divu_aft_rst", ALU_DIVU, 64'd100, 64'd7, 64'd14, DW);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
